// File: rtl/fp16_pkg.sv
// Shared constants, state encoding and class indices for the binary16
// multiplier sequencer and its classifier.
package fp16_pkg;

    localparam int          EXP_W    = 5;
    localparam int          MAN_W    = 10;
    localparam logic [4:0]  EXP_MAX  = 5'h1F;
    localparam int          QNAN_BIT = 9;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_LD_A    = 3'd2,
        S_LATCH_A = 3'd3,
        S_LD_B    = 3'd4,
        S_LATCH_B = 3'd5,
        S_WAIT    = 3'd6,
        S_OUT     = 3'd7
    } seq_state_t;

    localparam int CLS_SNAN = 0;
    localparam int CLS_QNAN = 1;
    localparam int CLS_INF  = 2;
    localparam int CLS_ZERO = 3;
    localparam int CLS_SUB  = 4;
    localparam int CLS_NORM = 5;
    localparam int CLS_N    = 6;

    typedef logic [CLS_N-1:0] fp_class_t;

endpackage

// File: rtl/fp16_mul_sequencer_if.sv
// Operand, multiplier-bus and result signals of the sequencer; slave is the
// sequencer's view, master is the controller/multiplier side.
interface fp16_mul_sequencer_if;

    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [15:0] mul_na;
    logic        mul_save;
    logic [15:0] mul_producto;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res;
    logic        snan;
    logic        qnan;
    logic        inf;
    logic        zero;
    logic        subnormal;
    logic        normal;
    logic        busy;

    modport slave (
        input  op_valid, op_a, op_b, mul_producto, res_ready,
        output op_ready, mul_na, mul_save, res_valid, res,
               snan, qnan, inf, zero, subnormal, normal, busy
    );

    modport master (
        output op_valid, op_a, op_b, mul_producto, res_ready,
        input  op_ready, mul_na, mul_save, res_valid, res,
               snan, qnan, inf, zero, subnormal, normal, busy
    );

endinterface

// File: rtl/fp16_classify.sv
// Combinational IEEE-754 binary16 classifier producing one-hot class flags.
module fp16_classify
    import fp16_pkg::*;
(
    input  logic [15:0] i_val,
    output fp_class_t   o_class
);

    logic [EXP_W-1:0] w_exp;
    logic [MAN_W-1:0] w_man;

    assign w_exp = i_val[14:10];
    assign w_man = i_val[9:0];

    always_comb begin
        o_class = '0;
        if (w_exp == EXP_MAX) begin
            if (w_man == '0)
                o_class[CLS_INF] = 1'b1;
            else if (w_man[QNAN_BIT])
                o_class[CLS_QNAN] = 1'b1;
            else
                o_class[CLS_SNAN] = 1'b1;
        end else if (w_exp == '0) begin
            if (w_man == '0)
                o_class[CLS_ZERO] = 1'b1;
            else
                o_class[CLS_SUB] = 1'b1;
        end else begin
            o_class[CLS_NORM] = 1'b1;
        end
    end

endmodule

// File: rtl/fp16_mul_sequencer.sv
// Drives the multiplier's serial SAVE/operand-bus load protocol for one
// operand pair, then captures and classifies the product.
module fp16_mul_sequencer
    import fp16_pkg::*;
#(
    parameter int RESULT_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    fp16_mul_sequencer_if.slave  bus
);

    localparam logic [3:0] LAT_LAST = 4'(RESULT_LAT - 1);

    seq_state_t  r_state;
    seq_state_t  w_next;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_na;
    logic [15:0] w_na_next;
    logic        r_save;
    logic        w_save_next;
    logic [3:0]  r_cnt;
    logic        w_accept;
    logic        w_wait_done;
    logic [15:0] r_res;
    fp_class_t   r_cls;
    fp_class_t   w_cls;
    logic        r_res_vld;

    fp16_classify u_classify (
        .i_val   (bus.mul_producto),
        .o_class (w_cls)
    );

    assign w_accept    = (r_state == S_IDLE) && bus.op_valid;
    assign w_wait_done = (r_cnt == LAT_LAST);

    // Bus value and strobe are derived from the next state so both leave a register.
    always_comb begin
        w_next    = r_state;
        w_na_next = r_na;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next    = S_ARM;
                    w_na_next = bus.op_a;
                end
            end
            S_ARM:     w_next = S_LD_A;
            S_LD_A:    w_next = S_LATCH_A;
            S_LATCH_A: begin
                w_next    = S_LD_B;
                w_na_next = r_b;
            end
            S_LD_B:    w_next = S_LATCH_B;
            S_LATCH_B: w_next = S_WAIT;
            S_WAIT:    if (w_wait_done) w_next = S_OUT;
            S_OUT:     if (bus.res_ready) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
        w_save_next = (w_next == S_ARM) || (w_next == S_LATCH_A) || (w_next == S_LATCH_B);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_na      <= '0;
            r_save    <= 1'b0;
            r_cnt     <= '0;
            r_res     <= '0;
            r_cls     <= '0;
            r_res_vld <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_na      <= w_na_next;
            r_save    <= w_save_next;
            r_res_vld <= (w_next == S_OUT);
            if ((r_state == S_WAIT) && !w_wait_done)
                r_cnt <= r_cnt + 4'd1;
            else
                r_cnt <= '0;
            // Product capture stage: value and its class register together.
            if ((r_state == S_WAIT) && w_wait_done) begin
                r_res <= bus.mul_producto;
                r_cls <= w_cls;
            end
        end
    end

    // Operand holding registers are pure data and need no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= bus.op_a;
            r_b <= bus.op_b;
        end
    end

    assign bus.op_ready  = (r_state == S_IDLE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.mul_na    = r_na;
    assign bus.mul_save  = r_save;
    assign bus.res_valid = r_res_vld;
    assign bus.res       = r_res;
    assign bus.snan      = r_cls[CLS_SNAN];
    assign bus.qnan      = r_cls[CLS_QNAN];
    assign bus.inf       = r_cls[CLS_INF];
    assign bus.zero      = r_cls[CLS_ZERO];
    assign bus.subnormal = r_cls[CLS_SUB];
    assign bus.normal    = r_cls[CLS_NORM];

endmodule

// File: tb/tb_fp16_mul_sequencer.sv
// Bench for fp16_mul_sequencer: a SAVE-protocol multiplier model per instance,
// a cycle-timeline reference model checked every cycle, and directed scenarios.
module tb_fp16_mul_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp16_mul_sequencer_if bus0();
    fp16_mul_sequencer_if bus1();

    logic        op_valid[2];
    logic [15:0] op_a[2];
    logic [15:0] op_b[2];
    logic        res_ready[2];
    logic        op_ready_o[2];
    logic        save_o[2];
    logic        res_valid_o[2];
    logic        busy_o[2];
    logic [15:0] na_o[2];
    logic [15:0] res_o[2];
    logic [5:0]  flags_o[2];

    // Multiplier model state
    int          m_st[2];
    int          m_cd[2];
    logic [15:0] m_a[2];
    logic [15:0] m_pend[2];
    logic [15:0] m_prod[2];
    logic        m_force[2];
    logic [15:0] m_fval[2];

    // Reference timeline state: e_t = cycle number since acceptance, 0 when idle
    int          e_t[2];
    logic        e_valid[2];
    logic        e_have[2];
    logic [15:0] e_a[2];
    logic [15:0] e_b[2];
    logic [15:0] e_na[2];
    logic [15:0] e_res[2];

    fp16_mul_sequencer #(.RESULT_LAT(1)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    fp16_mul_sequencer #(.RESULT_LAT(3)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    assign bus0.op_valid     = op_valid[0];
    assign bus0.op_a         = op_a[0];
    assign bus0.op_b         = op_b[0];
    assign bus0.res_ready    = res_ready[0];
    assign bus0.mul_producto = m_prod[0];
    assign op_ready_o[0]     = bus0.op_ready;
    assign save_o[0]         = bus0.mul_save;
    assign res_valid_o[0]    = bus0.res_valid;
    assign busy_o[0]         = bus0.busy;
    assign na_o[0]           = bus0.mul_na;
    assign res_o[0]          = bus0.res;
    assign flags_o[0]        = {bus0.snan, bus0.qnan, bus0.inf, bus0.zero, bus0.subnormal, bus0.normal};

    assign bus1.op_valid     = op_valid[1];
    assign bus1.op_a         = op_a[1];
    assign bus1.op_b         = op_b[1];
    assign bus1.res_ready    = res_ready[1];
    assign bus1.mul_producto = m_prod[1];
    assign op_ready_o[1]     = bus1.op_ready;
    assign save_o[1]         = bus1.mul_save;
    assign res_valid_o[1]    = bus1.res_valid;
    assign busy_o[1]         = bus1.busy;
    assign na_o[1]           = bus1.mul_na;
    assign res_o[1]          = bus1.res;
    assign flags_o[1]        = {bus1.snan, bus1.qnan, bus1.inf, bus1.zero, bus1.subnormal, bus1.normal};

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Simplified binary16 product: normal operands, truncation, inf/zero passthrough.
    function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
        logic        s;
        int          e;
        logic [21:0] m;
        logic [9:0]  f;
        s = a[15] ^ b[15];
        if (a[14:10] == 5'h1F || b[14:10] == 5'h1F) return {s, 5'h1F, 10'h000};
        if (a[14:10] == 5'h00 || b[14:10] == 5'h00) return {s, 15'h0000};
        m = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
        e = int'(a[14:10]) + int'(b[14:10]) - 15;
        if (m[21]) begin
            f = m[20:11];
            e = e + 1;
        end else begin
            f = m[19:10];
        end
        if (e >= 31) return {s, 5'h1F, 10'h000};
        if (e <= 0)  return {s, 15'h0000};
        return {s, 5'(e), f};
    endfunction

    function automatic logic [15:0] model_product(input int k, input logic [15:0] a, input logic [15:0] b);
        return m_force[k] ? m_fval[k] : fmul(a, b);
    endfunction

    // Flags ordered {snan, qnan, inf, zero, subnormal, normal}
    function automatic logic [5:0] cls(input logic [15:0] r);
        logic [14:0] mag;
        mag = r[14:0];
        if (mag > 15'h7C00)  return (mag >= 15'h7E00) ? 6'b010000 : 6'b100000;
        if (mag == 15'h7C00) return 6'b001000;
        if (mag == 15'h0000) return 6'b000100;
        if (mag < 15'h0400)  return 6'b000010;
        return 6'b000001;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Behavioural multiplier: NONE -> LOAD_A -> LOAD_B -> NONE on SAVE strobes.
    always @(posedge clk or negedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                m_st[k]   <= 0;
                m_cd[k]   <= 0;
                m_prod[k] <= 16'hDEAD;
            end else begin
                if (m_cd[k] != 0) begin
                    m_cd[k] <= m_cd[k] - 1;
                    if (m_cd[k] == 1) m_prod[k] <= m_pend[k];
                end
                case (m_st[k])
                    0: if (save_o[k]) begin
                        m_st[k]   <= 1;
                        m_prod[k] <= 16'hDEAD;
                    end
                    1: begin
                        m_a[k] <= na_o[k];
                        if (save_o[k]) m_st[k] <= 2;
                    end
                    default: if (save_o[k]) begin
                        m_st[k] <= 0;
                        if (lat(k) == 1) begin
                            m_prod[k] <= model_product(k, m_a[k], na_o[k]);
                        end else begin
                            m_pend[k] <= model_product(k, m_a[k], na_o[k]);
                            m_cd[k]   <= lat(k) - 1;
                        end
                    end
                endcase
            end
        end
    end

    // Reference timeline: strobes in cycles 1,3,5, result valid from cycle 6+L.
    always @(posedge clk or negedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                e_t[k]     <= 0;
                e_valid[k] <= 1'b0;
                e_have[k]  <= 1'b0;
                e_na[k]    <= 16'h0000;
                e_res[k]   <= 16'h0000;
            end else if (e_t[k] == 0) begin
                if (op_valid[k]) begin
                    e_t[k]  <= 1;
                    e_a[k]  <= op_a[k];
                    e_b[k]  <= op_b[k];
                    e_na[k] <= op_a[k];
                end
            end else if (e_valid[k]) begin
                if (res_ready[k]) begin
                    e_valid[k] <= 1'b0;
                    e_t[k]     <= 0;
                end
            end else begin
                e_t[k] <= e_t[k] + 1;
                if (e_t[k] == 3) e_na[k] <= e_b[k];
                if (e_t[k] + 1 == 6 + lat(k)) begin
                    e_valid[k] <= 1'b1;
                    e_have[k]  <= 1'b1;
                    e_res[k]   <= model_product(k, e_a[k], e_b[k]);
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("op_ready[%0d] t=%0d", k, e_t[k]), op_ready_o[k], e_t[k] == 0);
            chk($sformatf("busy[%0d] t=%0d", k, e_t[k]), busy_o[k], e_t[k] != 0);
            chk($sformatf("mul_save[%0d] t=%0d", k, e_t[k]), save_o[k],
                (e_t[k] == 1) || (e_t[k] == 3) || (e_t[k] == 5));
            chk($sformatf("mul_na[%0d] t=%0d", k, e_t[k]), na_o[k], e_na[k]);
            chk($sformatf("res_valid[%0d] t=%0d", k, e_t[k]), res_valid_o[k], e_valid[k]);
            chk($sformatf("res[%0d]", k), res_o[k], e_res[k]);
            chk($sformatf("flags[%0d]", k), flags_o[k], e_have[k] ? cls(e_res[k]) : 6'b000000);
        end
    end

    task automatic send(input int k, input logic [15:0] a, input logic [15:0] b, output int acc);
        bit ok;
        ok = 1'b0;
        op_valid[k] = 1'b1;
        op_a[k] = a;
        op_b[k] = b;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (op_ready_o[k]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept_timeout", ok, 1);
        @(posedge clk);
        #1;
        acc = cyc;
    endtask

    task automatic wait_valid(input int k, input int acc, output int c);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (res_valid_o[k]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("valid_timeout", ok, 1);
        c = cyc - acc + 1;
    endtask

    task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] r, output logic [5:0] f);
        int acc;
        int c;
        send(k, a, b, acc);
        op_valid[k] = 1'b0;
        op_a[k] = 16'hFFFF;
        op_b[k] = 16'hFFFF;
        wait_valid(k, acc, c);
        chk("latency", c, 6 + lat(k));
        r = res_o[k];
        f = flags_o[k];
        @(posedge clk);
        #1;
    endtask

    logic [6:0]  sv;
    logic [6:0]  vv;
    logic [15:0] nas[8];
    logic [15:0] r;
    logic [5:0]  f;
    int          acc;
    int          c;
    bit          stable;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            op_valid[k]  = 1'b0;
            op_a[k]      = 16'h0000;
            op_b[k]      = 16'h0000;
            res_ready[k] = 1'b1;
            m_force[k]   = 1'b0;
            m_fval[k]    = 16'h0000;
        end
        repeat (3) @(negedge clk);
        chk("reset_res", res_o[0], 16'h0000);
        chk("reset_valid", res_valid_o[0], 0);
        chk("reset_save", save_o[0], 0);
        chk("reset_na", na_o[0], 16'h0000);
        chk("reset_busy", busy_o[0], 0);
        chk("reset_flags", flags_o[0], 6'b000000);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Basic product 2.0 * 3.0
        send(0, 16'h4000, 16'h4200, acc);
        op_valid[0] = 1'b0;
        op_a[0] = 16'hFFFF;
        op_b[0] = 16'hFFFF;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            sv[i-1] = save_o[0];
            vv[i-1] = res_valid_o[0];
            nas[i]  = na_o[0];
        end
        chk("basic_save_cycles", sv, 7'b0010101);
        chk("basic_na_c1", nas[1], 16'h4000);
        chk("basic_na_c3", nas[3], 16'h4000);
        chk("basic_na_c4", nas[4], 16'h4200);
        chk("basic_na_c5", nas[5], 16'h4200);
        chk("basic_valid_cycle", vv, 7'b1000000);
        chk("basic_res", res_o[0], 16'h4600);
        chk("basic_normal", flags_o[0], 6'b000001);
        @(posedge clk);
        #1;

        // Special results
        run_op(0, 16'h7C00, 16'h4000, r, f);
        chk("inf_res", r, 16'h7C00);
        chk("inf_flag", f, 6'b001000);
        run_op(0, 16'h0000, 16'h4000, r, f);
        chk("zero_res", r, 16'h0000);
        chk("zero_flag", f, 6'b000100);

        // Classifier with fixed multiplier outputs
        m_force[0] = 1'b1;
        m_fval[0]  = 16'h7D00;
        run_op(0, 16'h4000, 16'h4000, r, f);
        chk("snan_flag", f, 6'b100000);
        m_fval[0] = 16'h7E00;
        run_op(0, 16'h4000, 16'h4000, r, f);
        chk("qnan_flag", f, 6'b010000);
        m_fval[0] = 16'h0001;
        run_op(0, 16'h4000, 16'h4000, r, f);
        chk("sub_flag", f, 6'b000010);
        chk("sub_onehot", $onehot(f), 1);
        m_force[0] = 1'b0;

        // Backpressure
        res_ready[0] = 1'b0;
        send(0, 16'h4000, 16'h4000, acc);
        op_valid[0] = 1'b0;
        op_a[0] = 16'hFFFF;
        wait_valid(0, acc, c);
        chk("bp_latency", c, 7);
        r = res_o[0];
        f = flags_o[0];
        chk("bp_res", r, 16'h4400);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_o[0] !== r || flags_o[0] !== f || res_valid_o[0] !== 1'b1 || op_ready_o[0] !== 1'b0)
                stable = 1'b0;
        end
        chk("bp_stable", stable, 1);
        res_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_ready_next", op_ready_o[0], 1);
        chk("bp_valid_drop", res_valid_o[0], 0);
        chk("bp_res_hold", res_o[0], 16'h4400);

        // Reset while loading B
        send(0, 16'h4200, 16'h4200, acc);
        op_valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_save", save_o[0], 0);
        chk("midrst_busy", busy_o[0], 0);
        chk("midrst_ready", op_ready_o[0], 1);
        chk("midrst_valid", res_valid_o[0], 0);
        chk("midrst_res", res_o[0], 16'h0000);
        chk("midrst_na", na_o[0], 16'h0000);
        chk("midrst_flags", flags_o[0], 6'b000000);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_op(0, 16'h3C00, 16'h3C00, r, f);
        chk("after_rst_res", r, 16'h3C00);
        chk("after_rst_flag", f, 6'b000001);

        // RESULT_LAT=3, two pairs back to back with operands changing after acceptance
        send(1, 16'h4000, 16'h4200, acc);
        op_a[1] = 16'h3C00;
        op_b[1] = 16'h4000;
        wait_valid(1, acc, c);
        chk("lat3_first_cycle", c, 9);
        chk("lat3_first_res", res_o[1], 16'h4600);
        send(1, 16'h3C00, 16'h4000, acc);
        op_valid[1] = 1'b0;
        op_a[1] = 16'h7C00;
        op_b[1] = 16'h7C00;
        wait_valid(1, acc, c);
        chk("lat3_second_cycle", c, 9);
        chk("lat3_second_res", res_o[1], 16'h4000);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
